// File: rtl/fetch_pkg.sv
// Shared types and constants for the byte-serial instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    TRAP  = 2'd2
  } fetch_state_e;

  localparam int unsigned INSTR_BYTES = 4;
  localparam int unsigned PC_STEP     = 4;
  localparam logic [31:0] RESET_PC    = 32'h0000_0000;

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: instruction-memory read port, decode handshake and redirect.
// The misaligned flag exists only when FETCH_MISALIGN_TRAP_EN is defined.
interface instruction_fetch_if #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned INSTR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]  imem_addr;
  logic [DATA_WIDTH-1:0]  imem_data;
  logic [INSTR_WIDTH-1:0] instr;
  logic [ADDR_WIDTH-1:0]  instr_pc;
  logic                   instr_valid;
  logic                   instr_ready;
  logic                   redirect;
  logic [ADDR_WIDTH-1:0]  redirect_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic                   misaligned;

  modport master (
    output imem_addr, instr, instr_pc, instr_valid, misaligned,
    input  imem_data, instr_ready, redirect, redirect_pc
  );
  modport slave (
    input  imem_addr, instr, instr_pc, instr_valid, misaligned,
    output imem_data, instr_ready, redirect, redirect_pc
  );
`else
  modport master (
    output imem_addr, instr, instr_pc, instr_valid,
    input  imem_data, instr_ready, redirect, redirect_pc
  );
  modport slave (
    input  imem_addr, instr, instr_pc, instr_valid,
    output imem_data, instr_ready, redirect, redirect_pc
  );
`endif
endinterface

// File: rtl/byte_assembler.sv
// Little-endian assembly register: byte k of the instruction lands in bits [8k+7:8k].
module byte_assembler #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned INSTR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear_i,
  input  logic                   cap_en_i,
  input  logic [1:0]             cap_idx_i,
  input  logic [DATA_WIDTH-1:0]  data_i,
  output logic [INSTR_WIDTH-1:0] instr_o
);
  logic [INSTR_WIDTH-1:0] asm_q, asm_d;

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    asm_d = asm_q;
    if (clear_i) begin
      asm_d = '0;
    end else if (cap_en_i) begin
      asm_d[int'(cap_idx_i)*DATA_WIDTH +: DATA_WIDTH] = data_i;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) asm_q <= '0;
    else     asm_q <= asm_d;
  end

  assign instr_o = asm_q;
endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: four byte reads per instruction, little-endian assembly, valid/ready to decode.
// Optional FETCH_MISALIGN_TRAP_EN parks misaligned reset/redirect targets in a TRAP state.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH  = 8,
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           INSTR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = fetch_pkg::RESET_PC
) (
  input logic                 clk,
  input logic                 rst,
  instruction_fetch_if.master bus
);
  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] instr_pc_q, instr_pc_d;
  logic [2:0]            issue_idx_q, issue_idx_d;
  logic [1:0]            cap_idx_q, cap_idx_d;
  logic                  rd_pend_q, rd_pend_d;
  logic                  asm_clear, cap_en;
  logic                  redirect_trap;

`ifdef FETCH_MISALIGN_TRAP_EN
  localparam fetch_state_e RESET_STATE = (RESET_PC[1:0] != 2'b00) ? TRAP : FETCH;
  assign redirect_trap = (bus.redirect_pc[1:0] != 2'b00);
`else
  localparam fetch_state_e RESET_STATE = FETCH;
  assign redirect_trap = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RESET_STATE;
      pc_q        <= RESET_PC;
      instr_pc_q  <= '0;
      issue_idx_q <= '0;
      cap_idx_q   <= '0;
      rd_pend_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_pc_q  <= instr_pc_d;
      issue_idx_q <= issue_idx_d;
      cap_idx_q   <= cap_idx_d;
      rd_pend_q   <= rd_pend_d;
    end
  end

  // Redirect wins over everything; a HOLD handshake on the same edge still completes
  // because decode samples instr_valid & instr_ready on that edge.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_pc_d  = instr_pc_q;
    issue_idx_d = issue_idx_q;
    cap_idx_d   = cap_idx_q;
    rd_pend_d   = 1'b0;
    asm_clear   = 1'b0;
    cap_en      = 1'b0;
    if (bus.redirect) begin
      pc_d        = bus.redirect_pc;
      issue_idx_d = '0;
      cap_idx_d   = '0;
      asm_clear   = 1'b1;
      state_d     = redirect_trap ? TRAP : FETCH;
    end else begin
      case (state_q)
        FETCH: begin
          if (issue_idx_q < 3'(INSTR_BYTES)) begin
            issue_idx_d = issue_idx_q + 3'd1;
            rd_pend_d   = 1'b1;
          end
          // Data for the read issued last cycle is on imem_data now.
          if (rd_pend_q) begin
            cap_en    = 1'b1;
            cap_idx_d = cap_idx_q + 2'd1;
            if (cap_idx_q == 2'(INSTR_BYTES - 1)) begin
              state_d    = HOLD;
              instr_pc_d = pc_q;
            end
          end
        end
        HOLD: begin
          if (bus.instr_ready) begin
            pc_d        = pc_q + ADDR_WIDTH'(PC_STEP);
            issue_idx_d = '0;
            cap_idx_d   = '0;
            asm_clear   = 1'b1;
            state_d     = FETCH;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.imem_addr = pc_q;
    if (state_q == FETCH) bus.imem_addr = pc_q + ADDR_WIDTH'(issue_idx_q[1:0]);
  end

  assign bus.instr_valid = (state_q == HOLD);
  assign bus.instr_pc    = instr_pc_q;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign bus.misaligned  = (state_q == TRAP);
`endif

  byte_assembler #(
    .DATA_WIDTH  (DATA_WIDTH),
    .INSTR_WIDTH (INSTR_WIDTH)
  ) u_byte_assembler (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (asm_clear),
    .cap_en_i  (cap_en),
    .cap_idx_i (cap_idx_q),
    .data_i    (bus.imem_data),
    .instr_o   (bus.instr)
  );
endmodule
